// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN front end and engine.
package cnn_pkg;

    localparam int IMG_W        = 28;
    localparam int K            = 5;
    localparam int PIX_W        = 8;
    localparam int OUT_W        = IMG_W - K + 1;
    localparam int NPIX         = IMG_W * IMG_W;
    localparam int NWIN         = OUT_W * OUT_W;
    localparam int DONE_TIMEOUT = 16;

    localparam int PIX_AW = $clog2(NPIX);
    localparam int CRD_W  = 5;
    localparam int WIN_W  = K * K * PIX_W;
    localparam int TMO_W  = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_SWEEP,
        S_WAIT_DONE,
        S_REPORT
    } feeder_state_t;

endpackage

// File: rtl/cnn_window_gather.sv
// Combinational K x K window extraction from the frame buffer.
// Byte (r*K+c) of the window is frame[(x+r)*IMG_W + (y+c)].
module cnn_window_gather
    import cnn_pkg::*;
(
    input  logic [CRD_W-1:0] x,
    input  logic [CRD_W-1:0] y,
    input  logic [PIX_W-1:0] frame [NPIX],
    output logic [WIN_W-1:0] win
);

    // Pack the window row-major, column fastest.
    always_comb begin
        win = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win[(r*K+c)*PIX_W +: PIX_W] =
                    frame[PIX_AW'((int'(x) + r) * IMG_W + int'(y) + c)];
            end
        end
    end

endmodule

// File: rtl/cnn_window_feeder.sv
// Frame loader and window sequencer in front of the convolution engine.
//
//  state       | meaning
//  ------------+----------------------------------------------------
//  S_IDLE      | waiting for the first pixel of a frame
//  S_LOAD      | storing the remaining pixels of the frame
//  S_KICK      | one-cycle CNN_START, window (0,0) loaded at its end
//  S_SWEEP     | one window per cycle, Y fastest, 576 windows
//  S_WAIT_DONE | waiting for CNN_DONE or the timeout
//  S_REPORT    | one-cycle RES_VALID strobe
module cnn_window_feeder
    import cnn_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             PIX_VALID,
    input  logic [PIX_W-1:0] PIX_DATA,
    output logic             PIX_READY,
    output logic             CNN_START,
    output logic [CRD_W-1:0] CNN_X,
    output logic [CRD_W-1:0] CNN_Y,
    output logic [WIN_W-1:0] CNN_IMGIN,
    input  logic             CNN_DONE,
    input  logic [3:0]       CNN_OUT,
    output logic             RES_VALID,
    output logic [3:0]       RES_CLASS,
    output logic             RES_ERR,
    output logic             BUSY
);

    feeder_state_t    state;
    logic [PIX_AW-1:0] pix_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [PIX_W-1:0]  mem [NPIX];
    logic [CRD_W-1:0]  nx, ny;
    logic [WIN_W-1:0]  gwin;
    logic              pix_accept;
    logic              last_win;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign PIX_READY  = nRST && (state == S_IDLE || state == S_LOAD);
    assign BUSY       = (state != S_IDLE);
    assign pix_accept = PIX_VALID && PIX_READY;
    assign last_win   = (CNN_X == CRD_W'(OUT_W-1)) && (CNN_Y == CRD_W'(OUT_W-1));

    // Coordinates of the window to present next cycle.
    always_comb begin
        nx = '0;
        ny = '0;
        if (state == S_SWEEP) begin
            if (CNN_Y == CRD_W'(OUT_W-1)) begin
                nx = CNN_X + CRD_W'(1);
                ny = '0;
            end else begin
                nx = CNN_X;
                ny = CNN_Y + CRD_W'(1);
            end
        end
    end

    cnn_window_gather u_gather (
        .x     (nx),
        .y     (ny),
        .frame (mem),
        .win   (gwin)
    );

    // Frame buffer write port; pix_cnt is 0 in IDLE so the first pixel lands at 0.
    always_ff @(posedge CLK) begin
        if (pix_accept) begin
            mem[pix_cnt] <= PIX_DATA;
        end
    end

    // Sequencing FSM with registered engine and result outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            pix_cnt   <= '0;
            tmo_cnt   <= '0;
            CNN_START <= 1'b0;
            CNN_X     <= '0;
            CNN_Y     <= '0;
            CNN_IMGIN <= '0;
            RES_VALID <= 1'b0;
            RES_CLASS <= '0;
            RES_ERR   <= 1'b0;
        end else begin
            CNN_START <= 1'b0;
            RES_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pix_accept) begin
                        pix_cnt <= PIX_AW'(1);
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pix_accept) begin
                        if (pix_cnt == PIX_AW'(NPIX-1)) begin
                            pix_cnt   <= '0;
                            CNN_START <= 1'b1;
                            state     <= S_KICK;
                        end else begin
                            pix_cnt <= pix_cnt + PIX_AW'(1);
                        end
                    end
                end
                S_KICK: begin
                    CNN_X     <= nx;
                    CNN_Y     <= ny;
                    CNN_IMGIN <= gwin;
                    state     <= S_SWEEP;
                end
                S_SWEEP: begin
                    if (last_win) begin
                        CNN_X     <= '0;
                        CNN_Y     <= '0;
                        CNN_IMGIN <= '0;
                        tmo_cnt   <= '0;
                        state     <= S_WAIT_DONE;
                    end else begin
                        CNN_X     <= nx;
                        CNN_Y     <= ny;
                        CNN_IMGIN <= gwin;
                    end
                end
                S_WAIT_DONE: begin
                    if (CNN_DONE) begin
                        RES_CLASS <= CNN_OUT;
                        RES_ERR   <= 1'b0;
                        RES_VALID <= 1'b1;
                        state     <= S_REPORT;
                    end else if (tmo_cnt == TMO_W'(DONE_TIMEOUT-1)) begin
                        RES_CLASS <= '0;
                        RES_ERR   <= 1'b1;
                        RES_VALID <= 1'b1;
                        state     <= S_REPORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_REPORT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Self-checking bench for cnn_window_feeder: frame loads, full window sweeps
// against a reference frame, result handshake, timeout and mid-sweep reset.
module tb_cnn_window_feeder;

    localparam int IMG   = 28;
    localparam int KW    = 5;
    localparam int OW    = 24;
    localparam int NP    = 784;
    localparam int NW    = 576;
    localparam int TMO   = 16;
    localparam int WW    = KW * KW * 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          PIX_VALID;
    logic [7:0]    PIX_DATA;
    logic          PIX_READY;
    logic          CNN_START;
    logic [4:0]    CNN_X;
    logic [4:0]    CNN_Y;
    logic [WW-1:0] CNN_IMGIN;
    logic          CNN_DONE;
    logic [3:0]    CNN_OUT;
    logic          RES_VALID;
    logic [3:0]    RES_CLASS;
    logic          RES_ERR;
    logic          BUSY;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]    ref_frame [NP];
    logic [WW-1:0] cap [NW];

    typedef struct {
        int         x;
        int         y;
        int         b;
        logic [7:0] val;
    } vec_t;
    vec_t tbl [10];

    cnn_window_feeder dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .PIX_VALID (PIX_VALID),
        .PIX_DATA  (PIX_DATA),
        .PIX_READY (PIX_READY),
        .CNN_START (CNN_START),
        .CNN_X     (CNN_X),
        .CNN_Y     (CNN_Y),
        .CNN_IMGIN (CNN_IMGIN),
        .CNN_DONE  (CNN_DONE),
        .CNN_OUT   (CNN_OUT),
        .RES_VALID (RES_VALID),
        .RES_CLASS (RES_CLASS),
        .RES_ERR   (RES_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference window straight from the frame: byte r*K+c = pixel (X+r, Y+c).
    function automatic logic [WW-1:0] exp_win(input int x, input int y);
        logic [WW-1:0] w = '0;
        for (int r = 0; r < KW; r++)
            for (int c = 0; c < KW; c++)
                w[(r*KW+c)*8 +: 8] = ref_frame[(x+r)*IMG + y + c];
        return w;
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < NP; i++) ref_frame[i] = 8'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NP; i++) ref_frame[i] = 8'($urandom);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {PIX_READY, CNN_START, CNN_X, CNN_Y, RES_VALID, RES_CLASS, RES_ERR, BUSY}, '0);
        chk({nm, "_imgin"}, CNN_IMGIN, '0);
    endtask

    // Streams ref_frame[0..npix-1]; returns at the falling edge of the last accept cycle.
    task automatic send_frame(input int gap_pct, input int npix);
        int n = 0;
        int guard = 0;
        while (n < npix && guard < npix * 20) begin
            @(negedge CLK);
            guard++;
            if ($urandom_range(0, 99) < gap_pct) begin
                PIX_VALID = 1'b0;
                PIX_DATA  = 8'($urandom);
            end else begin
                PIX_VALID = 1'b1;
                PIX_DATA  = ref_frame[n];
            end
            if (PIX_VALID && PIX_READY) n++;
        end
        if (n < npix) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: accepted %0d pixels, required %0d", n, npix);
        end
    endtask

    // Checks KICK, all windows in order, and the first WAIT_DONE cycle.
    task automatic run_sweep(input bit hold, input int stop_k, input bit capture);
        @(negedge CLK);
        PIX_VALID = hold;
        chk("kick_ctl", {CNN_START, PIX_READY, BUSY, RES_VALID}, 4'b1010);
        for (int k = 0; k < NW; k++) begin
            @(negedge CLK);
            if (hold) PIX_DATA = 8'($urandom);
            chk($sformatf("win_xy[%0d]", k), {CNN_X, CNN_Y}, {5'(k / OW), 5'(k % OW)});
            chk($sformatf("win_img[%0d]", k), CNN_IMGIN, exp_win(k / OW, k % OW));
            chk($sformatf("win_ctl[%0d]", k), {CNN_START, PIX_READY, BUSY}, 3'b001);
            if (capture) cap[k] = CNN_IMGIN;
            if (k == stop_k) begin
                nRST = 1'b0;
                #1;
                chk_all_zero("midreset");
                return;
            end
        end
        @(negedge CLK);
        chk("wait_entry_xy", {CNN_X, CNN_Y}, '0);
        chk("wait_entry_img", CNN_IMGIN, '0);
        chk("wait_entry_ctl", {CNN_START, PIX_READY, BUSY, RES_VALID}, 4'b0010);
    endtask

    // Called at the falling edge of the first WAIT_DONE cycle. dly<0: no DONE.
    task automatic wait_result(input int dly, input logic [3:0] cls);
        bit         err  = !(dly >= 0 && dly < TMO);
        int         rc   = err ? TMO : dly + 1;
        logic [3:0] ecls = err ? 4'd0 : cls;
        for (int c = 0; c <= rc + 2; c++) begin
            if (c > 0) @(negedge CLK);
            if (c < rc) begin
                chk($sformatf("wait_ctl[%0d]", c), {RES_VALID, PIX_READY, BUSY}, 3'b001);
                CNN_DONE = (c == dly);
                CNN_OUT  = (c == dly) ? cls : 4'($urandom);
            end else if (c == rc) begin
                CNN_DONE  = 1'b0;
                PIX_VALID = 1'b0;
                chk("report", {RES_VALID, RES_ERR, RES_CLASS, BUSY}, {1'b1, err, ecls, 1'b1});
            end else begin
                chk($sformatf("post_report[%0d]", c - rc), {RES_VALID, RES_ERR, RES_CLASS, BUSY, PIX_READY},
                    {1'b0, err, ecls, 1'b0, 1'b1});
                CNN_DONE = err && (c == rc + 1);
                CNN_OUT  = 4'd9;
            end
        end
        CNN_DONE = 1'b0;
    endtask

    task automatic chk_table();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl[%0d](%0d,%0d)b%0d", i, tbl[i].x, tbl[i].y, tbl[i].b),
                cap[tbl[i].x * OW + tbl[i].y][tbl[i].b*8 +: 8], tbl[i].val);
        end
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 8'd0};
        tbl[1] = '{0, 0, 1, 8'd1};
        tbl[2] = '{0, 0, 5, 8'd28};
        tbl[3] = '{0, 0, 24, 8'd116};
        tbl[4] = '{23, 23, 0, 8'd155};
        tbl[5] = '{23, 23, 24, 8'd15};
        tbl[6] = '{0, 1, 0, 8'd1};
        tbl[7] = '{1, 0, 0, 8'd28};
        tbl[8] = '{10, 5, 0, 8'd29};
        tbl[9] = '{10, 5, 12, 8'd87};

        nRST      = 1'b0;
        PIX_VALID = 1'b0;
        PIX_DATA  = '0;
        CNN_DONE  = 1'b0;
        CNN_OUT   = '0;

        // Reset and idle behaviour.
        #1;
        chk_all_zero("in_reset");
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_reset", {PIX_READY, BUSY, CNN_START, RES_VALID}, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("idle_no_start[%0d]", i), {CNN_START, BUSY, PIX_READY}, 3'b001);
        end

        // Ramp frame back-to-back, engine answers 2 cycles into WAIT_DONE.
        fill_ramp();
        send_frame(0, NP);
        run_sweep(1'b0, -1, 1'b1);
        chk_table();
        wait_result(2, 4'd7);

        // Ramp frame with gaps, PIX_VALID held through sweep and wait, no DONE.
        send_frame(30, NP);
        run_sweep(1'b1, -1, 1'b0);
        wait_result(-1, 4'd0);

        // Random frame with gaps, random answer time and class.
        fill_rand();
        send_frame(20, NP);
        run_sweep(1'b0, -1, 1'b0);
        wait_result($urandom_range(0, TMO - 2), 4'($urandom));

        // Reset while window (10,5) is presented, then a discarded partial frame.
        fill_ramp();
        send_frame(0, NP);
        run_sweep(1'b0, 10 * OW + 5, 1'b0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        fill_rand();
        send_frame(10, 100);
        @(negedge CLK);
        PIX_VALID = 1'b0;
        nRST      = 1'b0;
        #1;
        chk_all_zero("partial_reset");
        @(negedge CLK);
        nRST = 1'b1;
        fill_ramp();
        send_frame(0, NP);
        run_sweep(1'b0, -1, 1'b1);
        chk_table();
        // DONE on the last allowed wait cycle wins over the timeout.
        wait_result(TMO - 1, 4'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
